// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: comparator signedness, taken decode, mispredict
// redirect with a multi-cycle front-end flush, 2-bit BHT training and statistics.
module branch_resolve_unit #(
   parameter int unsigned n       = 32,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned FLUSH_C = 2
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         ex_valid_i,
   input  logic         ex_is_br_i,
   input  logic         ex_is_jmp_i,
   input  logic [2:0]   ex_funct3_i,
   output logic         br_signed_o,
   input  logic         br_less_i,
   input  logic         br_equal_i,
   input  logic [n-1:0] ex_pc_i,
   input  logic [n-1:0] ex_target_i,
   input  logic         ex_pred_taken_i,
   input  logic [n-1:0] if_pc_i,
   output logic         if_pred_taken_o,
   output logic         redirect_o,
   output logic [n-1:0] redirect_pc_o,
   output logic         flush_o,
   output logic [31:0]  br_cnt_o,
   output logic [31:0]  mispred_cnt_o
);

   localparam int unsigned Entries = 2 ** IDX_W;
   localparam int unsigned FcW     = (FLUSH_C < 2) ? 1 : $clog2(FLUSH_C + 1);

   logic [1:0]     bht_q [Entries];
   logic [FcW-1:0] flush_cnt_q;
   logic           redirect_q;
   logic [n-1:0]   redirect_pc_q;
   logic [31:0]    br_cnt_q;
   logic [31:0]    mispred_cnt_q;

   logic           resolve;
   logic           legal;
   logic           cond_taken;
   logic           br_res;
   logic           jmp_res;
   logic           taken;
   logic           mispred;
   logic [IDX_W-1:0] ex_idx;
   logic [IDX_W-1:0] if_idx;

   assign br_signed_o = ~ex_funct3_i[1];
   assign flush_o     = (flush_cnt_q != '0);

   // funct3 010/011 have no branch meaning and never train or count
   assign legal = (ex_funct3_i[2:1] != 2'b01);

   // Taken decode from comparator flags
   always_comb begin
      cond_taken = 1'b0;
      unique case (ex_funct3_i)
         3'b000:          cond_taken = br_equal_i;
         3'b001:          cond_taken = ~br_equal_i;
         3'b100, 3'b110:  cond_taken = br_less_i;
         3'b101, 3'b111:  cond_taken = ~br_less_i;
         default:         cond_taken = 1'b0;
      endcase
   end

   // Anything arriving while flushing is on the wrong path and is ignored
   assign resolve = ex_valid_i & ~flush_o & (ex_is_br_i | ex_is_jmp_i);
   // A jump flag wins if both are raised
   assign jmp_res = resolve & ex_is_jmp_i;
   assign br_res  = resolve & ex_is_br_i & ~ex_is_jmp_i;

   // Illegal encodings resolve as not taken
   assign taken   = jmp_res | (br_res & legal & cond_taken);
   // Jump targets are only known here, so every jump redirects
   assign mispred = jmp_res | (br_res & (taken != ex_pred_taken_i));

   assign ex_idx = ex_pc_i[IDX_W+1:2];
   assign if_idx = if_pc_i[IDX_W+1:2];

   // Read sees the pre-update value on a same-cycle write
   assign if_pred_taken_o = bht_q[if_idx][1];

   // Redirect pulse, corrected PC and flush down-counter
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         flush_cnt_q   <= '0;
      end else begin
         redirect_q <= mispred;
         if (mispred) begin
            redirect_pc_q <= taken ? ex_target_i : (ex_pc_i + n'(4));
            flush_cnt_q   <= FcW'(FLUSH_C);
         end else if (flush_cnt_q != '0) begin
            flush_cnt_q <= flush_cnt_q - FcW'(1);
         end
      end
   end

   assign redirect_o    = redirect_q;
   assign redirect_pc_o = redirect_pc_q;

   // Saturating 2-bit BHT training on legal resolved branches
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < Entries; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (br_res && legal) begin
         if (taken) begin
            if (bht_q[ex_idx] != 2'b11) bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
         end else begin
            if (bht_q[ex_idx] != 2'b00) bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
         end
      end
   end

   // Saturating branch and mispredict statistics
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (br_res && legal && (br_cnt_q != '1)) br_cnt_q <= br_cnt_q + 32'd1;
         if (mispred && (mispred_cnt_q != '1))    mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign br_cnt_o      = br_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised and directed checks of branch_resolve_unit against a behavioural model.
module tb_branch_resolve_unit;

   localparam int N  = 32;
   localparam int IW = 4;
   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ex_valid, ex_is_br, ex_is_jmp, br_signed, br_less, br_equal, ex_pred;
   logic [2:0]    ex_funct3;
   logic [N-1:0]  ex_pc, ex_target, if_pc, redirect_pc;
   logic          if_pred, redirect, flush;
   logic [31:0]   br_cnt, mp_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int          m_flush;
   bit          m_redir;
   logic [31:0] m_rpc;
   logic [31:0] m_br;
   logic [31:0] m_mp;
   int          m_bht [16];

   always #5 clk = ~clk;

   branch_resolve_unit #(.n(N), .IDX_W(IW), .FLUSH_C(FC)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .ex_valid_i     (ex_valid),
      .ex_is_br_i     (ex_is_br),
      .ex_is_jmp_i    (ex_is_jmp),
      .ex_funct3_i    (ex_funct3),
      .br_signed_o    (br_signed),
      .br_less_i      (br_less),
      .br_equal_i     (br_equal),
      .ex_pc_i        (ex_pc),
      .ex_target_i    (ex_target),
      .ex_pred_taken_i(ex_pred),
      .if_pc_i        (if_pc),
      .if_pred_taken_o(if_pred),
      .redirect_o     (redirect),
      .redirect_pc_o  (redirect_pc),
      .flush_o        (flush),
      .br_cnt_o       (br_cnt),
      .mispred_cnt_o  (mp_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flush = 0;
      m_redir = 0;
      m_rpc   = '0;
      m_br    = '0;
      m_mp    = '0;
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
   endtask

   function automatic bit is_unsigned(input logic [2:0] f3);
      return (f3 == 3'd2) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

   // Architectural branch semantics on the compared operands
   function automatic bit arch_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_regs(input string where);
      check_val({where, ".redirect"},    32'(redirect),    32'(m_redir));
      check_val({where, ".redirect_pc"}, redirect_pc,      m_rpc);
      check_val({where, ".flush"},       32'(flush),       32'(m_flush != 0));
      check_val({where, ".br_cnt"},      br_cnt,           m_br);
      check_val({where, ".mp_cnt"},      mp_cnt,           m_mp);
   endtask

   // One clock: drive at posedge+1, check combinational outputs, advance model, check after edge
   task automatic step(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                       input logic [31:0] tgt, input bit pred, input logic [31:0] ifpc);
      bit res, legal, tk, mp;
      int idx;
      ex_valid  = v;
      ex_is_br  = br;
      ex_is_jmp = jmp;
      ex_funct3 = f3;
      br_equal  = (a == b);
      br_less   = is_unsigned(f3) ? (a < b) : ($signed(a) < $signed(b));
      ex_pc     = pc;
      ex_target = tgt;
      ex_pred   = pred;
      if_pc     = ifpc;
      #1;
      check_val("br_signed", 32'(br_signed), 32'(!is_unsigned(f3)));
      check_val("if_pred", 32'(if_pred), 32'(m_bht[ifpc[5:2]] >= 2));
      res   = v && (m_flush == 0) && (br || jmp);
      legal = !((f3 == 3'd2) || (f3 == 3'd3));
      tk    = 0;
      mp    = 0;
      idx   = int'(pc[5:2]);
      if (res && jmp) begin
         tk = 1;
         mp = 1;
      end else if (res && br) begin
         tk = legal && arch_taken(f3, a, b);
         mp = (tk != pred);
         if (legal) begin
            m_br = m_br + 1;
            if (tk && m_bht[idx] < 3) m_bht[idx]++;
            else if (!tk && m_bht[idx] > 0) m_bht[idx]--;
         end
      end
      if (mp) begin
         m_flush = FC;
         m_rpc   = tk ? tgt : pc + 32'd4;
         m_mp    = m_mp + 1;
      end else if (m_flush > 0) begin
         m_flush--;
      end
      m_redir = mp;
      @(posedge clk);
      #1;
      check_regs("step");
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      ex_valid  = 0;
      ex_is_br  = 0;
      ex_is_jmp = 0;
      @(posedge clk);
      #1;
      model_reset();
      check_regs("reset");
      rst_n = 1'b1;
   endtask

   initial begin
      logic [31:0] a, b, pc, tgt, ifpc;
      logic [2:0]  f3;
      int          kind;
      rst_n = 1'b0;
      ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0; ex_funct3 = 0; br_less = 0; br_equal = 0;
      ex_pc = 0; ex_target = 0; ex_pred = 0; if_pc = 32'h0000_003C;
      @(posedge clk);
      #1;
      do_reset();
      check_val("reset.if_pred", 32'(if_pred), 32'd0);

      // BEQ taken, predicted not taken: redirect to target, 2-cycle flush
      step(1, 1, 0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 0, 32'h100);
      check_val("beq.redirect_pc", redirect_pc, 32'h140);
      idle(3);
      step(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h100);
      check_val("beq.bht0", 32'(if_pred), 32'd1);

      // BLTU not taken twice at index 1: 01 -> 00 -> 00, no redirect
      step(1, 1, 0, 3'd6, 32'd10, 32'd3, 32'h204, 32'h300, 0, 32'h204);
      step(1, 1, 0, 3'd6, 32'd10, 32'd3, 32'h204, 32'h300, 0, 32'h204);
      check_val("bltu.no_redirect", 32'(redirect), 32'd0);

      // JAL redirects to target; branches during the flush are ignored
      step(1, 0, 1, 3'd0, 0, 0, 32'h200, 32'h2F0, 0, 32'h0);
      check_val("jal.redirect_pc", redirect_pc, 32'h2F0);
      step(1, 1, 0, 3'd0, 32'd1, 32'd1, 32'h208, 32'h400, 0, 32'h208);
      step(1, 1, 0, 3'd1, 32'd1, 32'd2, 32'h208, 32'h400, 0, 32'h208);
      idle(2);

      // Train index 3 taken three times: saturates at 11
      for (int i = 0; i < 3; i++) step(1, 1, 0, 3'd5, 32'd7, 32'd7, 32'h00C, 32'h80, 1, 32'h00C);
      idle(2);
      step(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 32'h00C);
      check_val("train3.if_pred", 32'(if_pred), 32'd1);

      // Reset in the first flush cycle drops everything
      step(1, 0, 1, 3'd0, 0, 0, 32'h500, 32'h600, 0, 32'h0);
      check_val("midflush.flush", 32'(flush), 32'd1);
      do_reset();
      check_val("midflush.if_pred", 32'(if_pred), 32'd0);
      idle(1);

      // Random traffic including illegal funct3 and occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            kind = int'($urandom_range(0, 9));
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
            pc   = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) pc = 32'hFFFF_FFFC;
            tgt  = $urandom;
            ifpc = ($urandom_range(0, 1) == 0) ? pc : $urandom;
            step(kind != 0, kind >= 3, kind == 1 || kind == 9, f3, a, b, pc, tgt,
                 bit'($urandom_range(0, 1)), ifpc);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
